// File: rtl/scoreboard_reg_file.sv
// Multi-ported register file with a pending-write scoreboard.
// It has two write ports, READ_PORTS combinational read ports with write-to-read
// forwarding, and a busy bit per register set by issue and cleared by writeback.
module scoreboard_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             write_en_0,
  input  logic [ADDR_WIDTH-1:0]            write_addr_0,
  input  logic [DATA_WIDTH-1:0]            write_data_0,
  input  logic                             write_en_1,
  input  logic [ADDR_WIDTH-1:0]            write_addr_1,
  input  logic [DATA_WIDTH-1:0]            write_data_1,
  input  logic [READ_PORTS-1:0]            read_en,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_ready,
  input  logic                             issue_en,
  input  logic [ADDR_WIDTH-1:0]            issue_addr,
  input  logic                             flush,
  output logic [ADDR_WIDTH:0]              busy_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [ADDR_WIDTH:0]   r_busy_count;

  logic                  w_wr0_vld;
  logic                  w_wr1_vld;
  logic                  w_issue_vld;
  logic [DEPTH-1:0]      w_busy_next;

  // Register 0 is hard-wired to zero, so writes and issues aimed at it are dropped.
  assign w_wr0_vld   = write_en_0 && (write_addr_0 != '0);
  assign w_wr1_vld   = write_en_1 && (write_addr_1 != '0);
  assign w_issue_vld = issue_en && (issue_addr != '0);

  // Write port 1 is assigned last, so it wins when both ports target one address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is reset explicitly because the register file
      // must read back zero immediately after reset; this rules out RAM macros.
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      // NOTE: use non-blocking assignments for all clocked state, so every
      // register updates from values sampled at the same edge.
      if (w_wr0_vld) r_regs[write_addr_0] <= write_data_0;
      if (w_wr1_vld) r_regs[write_addr_1] <= write_data_1;
    end
  end

  // Priority runs from lowest to highest: writeback clear, then issue set, then flush.
  always_comb begin
    // NOTE: assign a default before the conditional updates, so no latch is inferred.
    w_busy_next = r_busy;
    if (w_wr0_vld)   w_busy_next[write_addr_0] = 1'b0;
    if (w_wr1_vld)   w_busy_next[write_addr_1] = 1'b0;
    if (w_issue_vld) w_busy_next[issue_addr]   = 1'b1;
    if (flush)       w_busy_next               = '0;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_next;
      r_busy_count <= (ADDR_WIDTH + 1)'($countones(w_busy_next));
    end
  end

  assign busy_count = r_busy_count;

  for (genvar g = 0; g < READ_PORTS; g++) begin : g_read
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_ready;

    assign w_addr = read_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

    // Forwarding is gated by rst so that outputs stay quiet while reset is held.
    always_comb begin
      w_data  = '0;
      w_ready = 1'b1;
      if (rst && read_en[g] && (w_addr != '0)) begin
        if (w_wr1_vld && (write_addr_1 == w_addr)) begin
          w_data = write_data_1;
        end else if (w_wr0_vld && (write_addr_0 == w_addr)) begin
          w_data = write_data_0;
        end else begin
          w_data  = r_regs[w_addr];
          w_ready = !r_busy[w_addr];
        end
      end
    end

    assign read_data[g*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign read_ready[g]                         = w_ready;
  end

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Directed bench for scoreboard_reg_file. It applies a table of per-cycle vectors,
// then runs hand-written sequences for reset asserted mid-operation and recovery.
module tb_scoreboard_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RP = 4;

  typedef struct {
    logic                   we0;
    logic [AW-1:0]          wa0;
    logic [DW-1:0]          wd0;
    logic                   we1;
    logic [AW-1:0]          wa1;
    logic [DW-1:0]          wd1;
    logic                   ie;
    logic [AW-1:0]          ia;
    logic                   fl;
    logic [RP-1:0]          ren;
    logic [RP-1:0][AW-1:0]  ra;
    logic [RP-1:0][DW-1:0]  exp_data;
    logic [RP-1:0]          exp_ready;
    logic [AW:0]            exp_cnt;
  } vec_t;

  logic                 clk;
  logic                 rst;
  logic                 write_en_0, write_en_1;
  logic [AW-1:0]        write_addr_0, write_addr_1;
  logic [DW-1:0]        write_data_0, write_data_1;
  logic [RP-1:0]        read_en;
  logic [RP*AW-1:0]     read_addr;
  logic [RP*DW-1:0]     read_data;
  logic [RP-1:0]        read_ready;
  logic                 issue_en;
  logic [AW-1:0]        issue_addr;
  logic                 flush;
  logic [AW:0]          busy_count;

  int n_chk = 0;
  int n_err = 0;
  vec_t tv[$];

  scoreboard_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_en_0   (write_en_0),
    .write_addr_0 (write_addr_0),
    .write_data_0 (write_data_0),
    .write_en_1   (write_en_1),
    .write_addr_1 (write_addr_1),
    .write_data_1 (write_data_1),
    .read_en      (read_en),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .read_ready   (read_ready),
    .issue_en     (issue_en),
    .issue_addr   (issue_addr),
    .flush        (flush),
    .busy_count   (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [RP*DW-1:0] act, input logic [RP*DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we0, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
    input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
    input logic ie, input logic [AW-1:0] ia, input logic fl,
    input logic [RP-1:0] ren, input logic [RP-1:0][AW-1:0] ra,
    input logic [RP-1:0][DW-1:0] ed, input logic [RP-1:0] er, input logic [AW:0] ec);
    vec_t v;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie; v.ia = ia; v.fl = fl;
    v.ren = ren; v.ra = ra;
    v.exp_data = ed; v.exp_ready = er; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic idle();
    write_en_0 = 0; write_addr_0 = '0; write_data_0 = '0;
    write_en_1 = 0; write_addr_1 = '0; write_data_1 = '0;
    issue_en = 0; issue_addr = '0; flush = 0;
    read_en = '0; read_addr = '0;
  endtask

  task automatic apply(input vec_t v);
    write_en_0 = v.we0; write_addr_0 = v.wa0; write_data_0 = v.wd0;
    write_en_1 = v.we1; write_addr_1 = v.wa1; write_data_1 = v.wd1;
    issue_en = v.ie; issue_addr = v.ia; flush = v.fl;
    read_en = v.ren; read_addr = v.ra;
  endtask

  initial begin
    // Port order in every packed field is {port3, port2, port1, port0}.
    tv.push_back(mk(0,0,0, 0,0,0, 0,0,0, 4'hF, {5'd5,5'd7,5'd9,5'd3},
                    {32'h0,32'h0,32'h0,32'h0}, 4'b1111, 0));
    tv.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0,0, 4'h0, {5'd5,5'd5,5'd5,5'd5},
                    {32'h0,32'h0,32'h0,32'h0}, 4'b1111, 0));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0,0, 4'b0100, {5'd0,5'd5,5'd0,5'd0},
                    {32'h0,32'hDEADBEEF,32'h0,32'h0}, 4'b1111, 0));
    tv.push_back(mk(1,7,32'h11, 1,7,32'h22, 0,0,0, 4'hF, {5'd7,5'd7,5'd5,5'd0},
                    {32'h22,32'h22,32'hDEADBEEF,32'h0}, 4'b1111, 0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,9,0, 4'hF, {5'd0,5'd0,5'd7,5'd7},
                    {32'h0,32'h0,32'h22,32'h22}, 4'b1111, 0));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0,0, 4'hF, {5'd9,5'd0,5'd0,5'd0},
                    {32'h0,32'h0,32'h0,32'h0}, 4'b0111, 1));
    tv.push_back(mk(1,9,32'h5, 0,0,0, 0,0,0, 4'hF, {5'd9,5'd9,5'd0,5'd0},
                    {32'h5,32'h5,32'h0,32'h0}, 4'b1111, 1));
    tv.push_back(mk(0,0,0, 0,0,0, 1,3,0, 4'hF, {5'd9,5'd0,5'd0,5'd0},
                    {32'h5,32'h0,32'h0,32'h0}, 4'b1111, 0));
    tv.push_back(mk(0,0,0, 1,3,32'hA, 1,3,0, 4'hF, {5'd3,5'd0,5'd0,5'd0},
                    {32'hA,32'h0,32'h0,32'h0}, 4'b1111, 1));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0,0, 4'hF, {5'd3,5'd0,5'd0,5'd0},
                    {32'hA,32'h0,32'h0,32'h0}, 4'b0111, 1));
    tv.push_back(mk(0,0,0, 0,0,0, 1,3,0, 4'hF, {5'd3,5'd0,5'd0,5'd0},
                    {32'hA,32'h0,32'h0,32'h0}, 4'b0111, 1));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1,0, 4'hF, {5'd3,5'd0,5'd0,5'd0},
                    {32'hA,32'h0,32'h0,32'h0}, 4'b0111, 1));
    tv.push_back(mk(0,0,0, 0,0,0, 1,2,0, 4'hF, {5'd3,5'd0,5'd0,5'd0},
                    {32'hA,32'h0,32'h0,32'h0}, 4'b0111, 2));
    tv.push_back(mk(0,0,0, 0,0,0, 1,4,0, 4'hF, {5'd3,5'd0,5'd0,5'd0},
                    {32'hA,32'h0,32'h0,32'h0}, 4'b0111, 3));
    tv.push_back(mk(0,0,0, 0,0,0, 1,6,1, 4'hF, {5'd1,5'd2,5'd4,5'd3},
                    {32'h0,32'h0,32'h0,32'hA}, 4'b0000, 4));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0,0, 4'hF, {5'd1,5'd2,5'd4,5'd6},
                    {32'h0,32'h0,32'h0,32'h0}, 4'b1111, 0));
    tv.push_back(mk(1,0,32'hFFFF, 1,0,32'hFFFF, 1,0,0, 4'hF, {5'd0,5'd0,5'd0,5'd0},
                    {32'h0,32'h0,32'h0,32'h0}, 4'b1111, 0));
    tv.push_back(mk(1,10,32'h100, 1,11,32'h200, 0,0,0, 4'hF, {5'd10,5'd11,5'd0,5'd0},
                    {32'h100,32'h200,32'h0,32'h0}, 4'b1111, 0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,12,0, 4'hF, {5'd10,5'd11,5'd0,5'd0},
                    {32'h100,32'h200,32'h0,32'h0}, 4'b1111, 0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,13,0, 4'hF, {5'd12,5'd0,5'd0,5'd0},
                    {32'h0,32'h0,32'h0,32'h0}, 4'b0111, 1));
    tv.push_back(mk(1,12,32'h1, 1,13,32'h2, 0,0,0, 4'hF, {5'd12,5'd13,5'd0,5'd0},
                    {32'h1,32'h2,32'h0,32'h0}, 4'b1111, 2));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0,0, 4'hF, {5'd12,5'd13,5'd0,5'd0},
                    {32'h1,32'h2,32'h0,32'h0}, 4'b1111, 0));

    // While reset is held, the outputs stay quiet even with a forwarding write active.
    rst = 1'b0;
    idle();
    write_en_1 = 1; write_addr_1 = 7; write_data_1 = 32'h55;
    read_en = 4'hF; read_addr = {5'd7, 5'd7, 5'd7, 5'd7};
    #12;
    check("reset data", read_data, '0);
    check("reset ready", {124'b0, read_ready}, {124'b0, 4'hF});
    check("reset count", {122'b0, busy_count}, '0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      apply(tv[i]);
      #2;
      check($sformatf("v%0d data", i), read_data, tv[i].exp_data);
      check($sformatf("v%0d ready", i), {124'b0, read_ready}, {124'b0, tv[i].exp_ready});
      check($sformatf("v%0d count", i), {122'b0, busy_count}, {122'b0, tv[i].exp_cnt});
    end

    // Reset asserted mid-cycle, while r15 is busy and a forwarding write is active.
    @(negedge clk);
    idle();
    issue_en = 1; issue_addr = 15;
    @(negedge clk);
    idle();
    write_en_1 = 1; write_addr_1 = 14; write_data_1 = 32'h1234;
    issue_en = 1; issue_addr = 20;
    read_en = 4'hF; read_addr = {5'd15, 5'd14, 5'd14, 5'd5};
    #2;
    check("pre-rst data", read_data, {32'h0, 32'h1234, 32'h1234, 32'hDEADBEEF});
    check("pre-rst ready", {124'b0, read_ready}, {124'b0, 4'b0111});
    check("pre-rst count", {122'b0, busy_count}, 1);
    #1 rst = 1'b0;
    #1;
    check("mid-rst data", read_data, '0);
    check("mid-rst ready", {124'b0, read_ready}, {124'b0, 4'hF});
    check("mid-rst count", {122'b0, busy_count}, '0);
    // Reset is held across a clock edge with the write and issue still driven.
    @(negedge clk);
    rst = 1'b1;
    idle();
    read_en = 4'hF; read_addr = {5'd14, 5'd15, 5'd5, 5'd20};
    #2;
    check("post-rst data", read_data, '0);
    check("post-rst ready", {124'b0, read_ready}, {124'b0, 4'hF});
    check("post-rst count", {122'b0, busy_count}, '0);

    // The first edge after reset is released behaves normally.
    @(negedge clk);
    idle();
    write_en_0 = 1; write_addr_0 = 5; write_data_0 = 32'h77;
    issue_en = 1; issue_addr = 8;
    @(negedge clk);
    idle();
    read_en = 4'hF; read_addr = {5'd5, 5'd8, 5'd0, 5'd0};
    #2;
    check("recover data", read_data, {32'h77, 32'h0, 32'h0, 32'h0});
    check("recover ready", {124'b0, read_ready}, {124'b0, 4'b1011});
    check("recover count", {122'b0, busy_count}, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/scoreboard_reg_file.md
SCOREBOARD_REG_FILE -- requirements
Module: scoreboard_reg_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_PORTS, default 4, number of independent read ports (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports write_en_0 / write_en_1, input, 1 each, write-port enables.
REQ-007 SHALL have ports write_addr_0 / write_addr_1, input, ADDR_WIDTH each, write addresses.
REQ-008 SHALL have ports write_data_0 / write_data_1, input, DATA_WIDTH each, write data.
REQ-009 SHALL have port read_en, input, READ_PORTS, per-port read enable.
REQ-010 SHALL have port read_addr, input, READ_PORTS*ADDR_WIDTH, packed addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port read_data, output, READ_PORTS*DATA_WIDTH, packed read data, same packing.
REQ-012 SHALL have port read_ready, output, READ_PORTS, 1 = read_data of port i is architecturally current.
REQ-013 SHALL have ports issue_en, input, 1, and issue_addr, input, ADDR_WIDTH, marking a destination register as pending.
REQ-014 SHALL have port flush, input, 1, discards all pending marks.
REQ-015 SHALL have port busy_count, output, ADDR_WIDTH+1, registered number of pending registers.

Function
REQ-016 Register 0 SHALL always read 0, never be written, never be marked busy.
REQ-017 Write port k SHALL update register write_addr_k at the clock edge when write_en_k=1 and write_addr_k!=0.
REQ-018 Both write ports to the same address in one cycle: port 1 SHALL win.
REQ-019 Reads SHALL be combinational, zero latency; read_en[i]=0 gives read_data 0 and read_ready 1.
REQ-020 Read forwarding priority per port: addr 0 -> 0; match write port 1 (enabled, addr!=0) -> write_data_1; else match write port 0 -> write_data_0; else stored value.
REQ-021 Busy vector (one bit per register) SHALL set bit issue_addr at the edge when issue_en=1, issue_addr!=0, flush=0.
REQ-022 Busy bit SHALL clear at the edge when an enabled write port targets it, unless REQ-023 applies.
REQ-023 Issue and writeback to the same address in one cycle: issue SHALL win (bit stays/becomes 1).
REQ-024 flush=1 SHALL clear all busy bits at the edge, overriding issue and writeback clears; register writes still occur.
REQ-025 read_ready[i] SHALL be 1 when addr 0, or busy bit clear, or forwarded from a write port this cycle; else 0.
REQ-026 busy_count SHALL equal the population count of the busy vector after each edge (0..2**ADDR_WIDTH-1).
REQ-027 Issuing an already-busy register SHALL leave it busy and busy_count unchanged.

Reset
REQ-028 While rst=0, all registers and busy bits SHALL be 0 asynchronously, busy_count=0.
REQ-029 While rst=0, read_data SHALL be 0 and read_ready all 1 regardless of inputs.
REQ-030 Reset asserted mid-operation SHALL discard pending writes/issues of that cycle; first edge after release SHALL behave normally.

Verification
REQ-031 Reset, write r5=0xDEADBEEF via port 0, next cycle read port 2 addr 5 -> 0xDEADBEEF, read_ready=1.
REQ-032 Same cycle write_addr_0=write_addr_1=7, data 0x11/0x22; read addr 7 that cycle -> 0x22; next cycle -> 0x22.
REQ-033 Issue r9; next cycle read r9 -> read_ready=0, busy_count=1; write r9=0x5 -> read_ready=1, data 0x5 same cycle; next cycle busy_count=0.
REQ-034 Busy r3, then issue r3 and write r3=0xA same cycle -> r3=0xA stored, busy stays 1, busy_count=1.
REQ-035 Issue r1,r2,r4 over three cycles, then flush with issue r6 -> busy_count=0, read_ready all 1.
REQ-036 Write r0=0xFFFF and issue r0 -> read r0=0, read_ready=1, busy_count=0; assert rst mid-test -> all reads 0 immediately.
